// File: rtl/mips_pkg.sv
// Shared MIPS register-file types, sizes and well-known register addresses.
package mips_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  localparam int        REG_COUNT = 32;
  localparam reg_addr_t REG_ZERO  = 5'd0;
  localparam reg_addr_t REG_SP    = 5'd29;
  localparam reg_addr_t REG_RA    = 5'd31;

endpackage

// File: rtl/wr_decoder.sv
// One-hot write-enable demux for the register file; bit 0 never fires
// because register 0 is hardwired to zero.
import mips_pkg::*;

module wr_decoder #(
  parameter int ADDR_W = $bits(reg_addr_t)
) (
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  output logic [2**ADDR_W-1:0]   sel
);

  always_comb begin
    // NOTE: default every output first so no path through the block leaves it unassigned (no latch).
    sel = '0;
    if (we) sel[wa] = 1'b1;
    sel[0] = 1'b0;
  end

endmodule

// File: rtl/reg_file.sv
// MIPS register file: 2**ADDR_W x DATA_W, two combinational read ports, one
// clocked write port. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
import mips_pkg::*;

module reg_file #(
  parameter int DATA_W = $bits(word_t),
  parameter int ADDR_W = $bits(reg_addr_t)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0]   wsel;
  logic [DATA_W-1:0] regs [NREG];

  wr_decoder #(.ADDR_W(ADDR_W)) u_wr_decoder (
    .we  (we),
    .wa  (wa),
    .sel (wsel)
  );

  assign regs[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    logic [DATA_W-1:0] q;

    // NOTE: every register sits on the async reset, so this storage maps to flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignment keeps the update at the edge, after all reads of the old value.
      if (!rst_n)       q <= '0;
      else if (wsel[i]) q <= wd;
    end

    assign regs[i] = q;
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  assign wr_live = we && (wa != ADDR_W'(REG_ZERO));
  assign rd1 = (wr_live && ra1 == wa) ? wd : regs[ra1];
  assign rd2 = (wr_live && ra2 == wa) ? wd : regs[ra2];
`else
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
`endif

  // Unknown write address would scribble an unpredictable register.
  always @(posedge clk) begin
    if (rst_n && we) begin
      assert (!$isunknown(wa))
        else $error("reg_file: write enabled with unknown address %b", wa);
    end
  end

endmodule
